// File: rtl/keycode_event_tracker.sv
// Debounces the MicroBlaze keycode GPIO words, diffs committed snapshots into
// press/release events, adds frame-locked typematic repeats and queues them in a FIFO.
module keycode_event_tracker #(
    parameter int NUM_SLOTS     = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int STABLE_CYCLES = 4,
    parameter int REPEAT_DELAY  = 30,
    parameter int REPEAT_RATE   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] keycode0_gpio,
    input  logic [31:0] keycode1_gpio,
    input  logic        frame_clk,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [7:0]  evt_code,
    output logic [1:0]  evt_type,
    output logic        overflow,
    input  logic        overflow_clr,
    output logic [3:0]  key_count,
    output logic        any_key
);
    localparam int SW  = NUM_SLOTS * 8;
    localparam int SIW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CW  = $clog2(STABLE_CYCLES + 1);
    localparam int RW  = $clog2(REPEAT_DELAY + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [1:0] EVT_PRESS = 2'b01;
    localparam logic [1:0] EVT_REL   = 2'b10;
    localparam logic [1:0] EVT_RPT   = 2'b11;

    typedef enum logic [1:0] {IDLE, SCAN_REL, SCAN_PRESS} state_t;

    function automatic logic [7:0] slot_of(input logic [SW-1:0] s, input int i);
        return s[i*8 +: 8];
    endfunction

    function automatic logic has_err(input logic [SW-1:0] s);
        logic e = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) if (s[i*8 +: 8] == 8'h01) e = 1'b1;
        return e;
    endfunction

    function automatic logic in_set(input logic [SW-1:0] s, input logic [7:0] code);
        logic f = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) if (s[i*8 +: 8] == code) f = 1'b1;
        return f;
    endfunction

    function automatic logic dup_below(input logic [SW-1:0] s, input int idx, input logic [7:0] code);
        logic f = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) if (i < idx && s[i*8 +: 8] == code) f = 1'b1;
        return f;
    endfunction

    function automatic logic [3:0] count_keys(input logic [SW-1:0] s);
        logic [3:0] n = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (s[i*8 +: 8] != 8'h00 && !dup_below(s, i, s[i*8 +: 8])) n = n + 4'd1;
        return n;
    endfunction

    logic [63:0]    gpio_all;
    logic [SW-1:0]  raw, raw_p0, cand_p1, old_snap, new_snap;
    logic           raw_err, cand_vld;
    logic [CW-1:0]  stb_cnt;
    state_t         state;
    logic [SIW-1:0] idx;
    logic [7:0]     cur_old, cur_new;
    logic           rel_hit, prs_hit, scan_push, last_slot;

    assign gpio_all  = {keycode1_gpio, keycode0_gpio};
    assign raw       = gpio_all[SW-1:0];
    assign raw_err   = has_err(raw);
    assign cur_old   = slot_of(old_snap, int'(idx));
    assign cur_new   = slot_of(new_snap, int'(idx));
    assign last_slot = (idx == SIW'(NUM_SLOTS - 1));
    // Duplicates inside one snapshot report only from their lowest slot.
    assign rel_hit   = (state == SCAN_REL) && cur_old != 8'h00 && !in_set(new_snap, cur_old)
                       && !dup_below(old_snap, int'(idx), cur_old);
    assign prs_hit   = (state == SCAN_PRESS) && cur_new != 8'h00 && !in_set(old_snap, cur_new)
                       && !dup_below(new_snap, int'(idx), cur_new);
    assign scan_push = rel_hit | prs_hit;

    // Stage p0/p1: stability filter, candidate latch and diff FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_p0    <= '0;
            stb_cnt   <= '0;
            cand_p1   <= '0;
            cand_vld  <= 1'b0;
            state     <= IDLE;
            idx       <= '0;
            old_snap  <= '0;
            new_snap  <= '0;
            key_count <= 4'd0;
            any_key   <= 1'b0;
        end else begin
            raw_p0 <= raw;
            if (raw_err || raw != raw_p0)
                stb_cnt <= '0;
            else if (stb_cnt != CW'(STABLE_CYCLES))
                stb_cnt <= stb_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (cand_vld) begin
                        cand_vld <= 1'b0;
                        if (cand_p1 != old_snap) begin
                            new_snap <= cand_p1;
                            idx      <= '0;
                            state    <= SCAN_REL;
                        end
                    end
                end
                SCAN_REL: begin
                    idx <= last_slot ? '0 : idx + 1'b1;
                    if (last_slot) state <= SCAN_PRESS;
                end
                default: begin
                    idx <= last_slot ? '0 : idx + 1'b1;
                    if (last_slot) begin
                        old_snap <= new_snap;
                        state    <= IDLE;
                    end
                end
            endcase
            // A fresh candidate overrides any consumption in the same cycle.
            if (!raw_err && raw == raw_p0 && stb_cnt == CW'(STABLE_CYCLES - 1)) begin
                cand_p1  <= raw_p0;
                cand_vld <= 1'b1;
            end
            key_count <= count_keys(old_snap);
            any_key   <= (count_keys(old_snap) != 4'd0);
        end
    end

    logic          fs_p0, fs_p1, fs_p2, frame_tick;
    logic [7:0]    rpt_code, rpt_pend_code;
    logic          rpt_vld, rpt_pend, rpt_kill, rpt_due, pend_drop;
    logic [RW-1:0] rpt_cnt;
    logic          push_vld;
    logic [7:0]    push_code;
    logic [1:0]    push_type;

    assign frame_tick = fs_p1 & ~fs_p2;
    assign rpt_kill   = rel_hit && rpt_vld && cur_old == rpt_code;
    assign rpt_due    = frame_tick && rpt_vld && !rpt_kill && !prs_hit
                        && rpt_cnt == RW'(REPEAT_DELAY - 1);

    always_comb begin
        push_vld  = 1'b0;
        push_code = 8'h00;
        push_type = 2'b00;
        pend_drop = 1'b0;
        if (scan_push) begin
            push_vld  = 1'b1;
            push_code = rel_hit ? cur_old : cur_new;
            push_type = rel_hit ? EVT_REL : EVT_PRESS;
            pend_drop = rpt_due && rpt_pend;
        end else if (rpt_pend) begin
            push_vld  = 1'b1;
            push_code = rpt_pend_code;
            push_type = EVT_RPT;
        end else if (rpt_due) begin
            push_vld  = 1'b1;
            push_code = rpt_code;
            push_type = EVT_RPT;
        end
    end

    // Stage p0..p2: frame synchroniser, repeat timer and pending repeat slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_p0         <= 1'b0;
            fs_p1         <= 1'b0;
            fs_p2         <= 1'b0;
            rpt_code      <= 8'h00;
            rpt_vld       <= 1'b0;
            rpt_cnt       <= '0;
            rpt_pend      <= 1'b0;
            rpt_pend_code <= 8'h00;
        end else begin
            fs_p0 <= frame_clk;
            fs_p1 <= fs_p0;
            fs_p2 <= fs_p1;
            if (prs_hit) begin
                rpt_code <= cur_new;
                rpt_vld  <= 1'b1;
                rpt_cnt  <= '0;
            end else if (rpt_kill) begin
                rpt_vld <= 1'b0;
            end else if (frame_tick && rpt_vld) begin
                rpt_cnt <= rpt_due ? RW'(REPEAT_DELAY - REPEAT_RATE) : rpt_cnt + 1'b1;
            end
            if (scan_push) begin
                if (rpt_due && !rpt_pend) begin
                    rpt_pend      <= 1'b1;
                    rpt_pend_code <= rpt_code;
                end
            end else if (rpt_pend) begin
                rpt_pend <= rpt_due;
                if (rpt_due) rpt_pend_code <= rpt_code;
            end
        end
    end

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [AW:0]   count, after_pop, cnt_next;
    logic          pop, push_ok, push_drop;
    logic [9:0]    head_next;

    assign pop       = evt_valid & evt_ready;
    assign push_ok   = push_vld && (count != (AW+1)'(FIFO_DEPTH) || pop);
    assign push_drop = push_vld && !push_ok;
    assign after_pop = count - {{AW{1'b0}}, pop};
    assign cnt_next  = after_pop + {{AW{1'b0}}, push_ok};
    assign rd_next   = pop ? rd_ptr + 1'b1 : rd_ptr;

    // Write-through when the pushed entry becomes the head immediately.
    always_comb begin
        head_next = 10'd0;
        if (cnt_next == '0)
            head_next = 10'd0;
        else if (after_pop == '0)
            head_next = {push_type, push_code};
        else
            head_next = mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {push_type, push_code};
    end

    // Stage p2: FIFO pointers, registered head and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            evt_valid <= 1'b0;
            evt_code  <= 8'h00;
            evt_type  <= 2'b00;
            overflow  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr    <= rd_next;
            count     <= cnt_next;
            evt_valid <= (cnt_next != '0);
            {evt_type, evt_code} <= head_next;
            if (push_drop || pend_drop)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_keycode_event_tracker.sv
// Directed bench for keycode_event_tracker: debounce, diff ordering, repeats,
// FIFO overflow, rollover-error suppression and reset mid-scan.
module tb_keycode_event_tracker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] keycode0_gpio = 32'h0;
    logic [31:0] keycode1_gpio = 32'h0;
    logic        frame_clk = 1'b0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [7:0]  evt_code;
    logic [1:0]  evt_type;
    logic        overflow;
    logic        overflow_clr = 1'b0;
    logic [3:0]  key_count;
    logic        any_key;

    int n_vec = 0;
    int n_bad = 0;

    keycode_event_tracker dut (
        .clk           (clk),
        .reset         (reset),
        .keycode0_gpio (keycode0_gpio),
        .keycode1_gpio (keycode1_gpio),
        .frame_clk     (frame_clk),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_code      (evt_code),
        .evt_type      (evt_type),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr),
        .key_count     (key_count),
        .any_key       (any_key)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1;
        cycles(4);
        frame_clk = 1'b0;
        cycles(4);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] code, input logic [1:0] typ);
        int w = 0;
        while (!evt_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk_eq({tag, ".valid"}, {31'd0, evt_valid}, 32'd1);
        if (evt_valid) begin
            chk_eq({tag, ".code"}, {24'd0, evt_code}, {24'd0, code});
            chk_eq({tag, ".type"}, {30'd0, evt_type}, {30'd0, typ});
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        cycles(3);
        reset = 1'b0;
        cycles(1);
        chk_eq("rst.valid", {31'd0, evt_valid}, 32'd0);
        chk_eq("rst.code", {24'd0, evt_code}, 32'd0);
        chk_eq("rst.type", {30'd0, evt_type}, 32'd0);
        chk_eq("rst.ovf", {31'd0, overflow}, 32'd0);
        chk_eq("rst.count", {28'd0, key_count}, 32'd0);
        chk_eq("rst.any", {31'd0, any_key}, 32'd0);

        // Single key press
        keycode0_gpio = 32'h0000_0004;
        pop_chk("t1.press04", 8'h04, 2'b01);
        cycles(15);
        chk_eq("t1.empty", {31'd0, evt_valid}, 32'd0);
        chk_eq("t1.count", {28'd0, key_count}, 32'd1);
        chk_eq("t1.any", {31'd0, any_key}, 32'd1);

        // Release, then a bouncing input that never settles on a new value
        keycode0_gpio = 32'h0;
        pop_chk("t2.rel04", 8'h04, 2'b10);
        for (int i = 0; i < 10; i++) begin
            keycode0_gpio = 32'h0000_0004;
            cycles(2);
            keycode0_gpio = 32'h0;
            cycles(2);
        end
        cycles(30);
        chk_eq("t2.noevt", {31'd0, evt_valid}, 32'd0);
        chk_eq("t2.count", {28'd0, key_count}, 32'd0);

        // Diff ordering: releases first, then presses
        keycode0_gpio = 32'h0000_0704;
        pop_chk("t3.press04", 8'h04, 2'b01);
        pop_chk("t3.press07", 8'h07, 2'b01);
        cycles(15);
        keycode0_gpio = 32'h0000_1607;
        pop_chk("t3.rel04", 8'h04, 2'b10);
        pop_chk("t3.press16", 8'h16, 2'b01);
        cycles(15);
        chk_eq("t3.empty", {31'd0, evt_valid}, 32'd0);
        chk_eq("t3.count", {28'd0, key_count}, 32'd2);
        keycode0_gpio = 32'h0707_1607;
        cycles(40);
        chk_eq("t3.dup.noevt", {31'd0, evt_valid}, 32'd0);
        chk_eq("t3.dup.count", {28'd0, key_count}, 32'd2);
        keycode1_gpio = 32'h2C00_0000;
        pop_chk("t3.press2C", 8'h2C, 2'b01);
        cycles(15);
        chk_eq("t3.slot7.count", {28'd0, key_count}, 32'd3);
        keycode0_gpio = 32'h0;
        keycode1_gpio = 32'h0;
        pop_chk("t3.rel07", 8'h07, 2'b10);
        pop_chk("t3.rel16", 8'h16, 2'b10);
        pop_chk("t3.rel2C", 8'h2C, 2'b10);
        cycles(15);

        // Typematic repeat at frames 30, 36 and 42
        keycode0_gpio = 32'h0000_001A;
        pop_chk("t4.press1A", 8'h1A, 2'b01);
        repeat (29) frame_pulse();
        chk_eq("t4.f29.noevt", {31'd0, evt_valid}, 32'd0);
        frame_pulse();
        pop_chk("t4.rpt30", 8'h1A, 2'b11);
        repeat (5) frame_pulse();
        chk_eq("t4.f35.noevt", {31'd0, evt_valid}, 32'd0);
        frame_pulse();
        pop_chk("t4.rpt36", 8'h1A, 2'b11);
        repeat (6) frame_pulse();
        pop_chk("t4.rpt42", 8'h1A, 2'b11);
        keycode0_gpio = 32'h0;
        pop_chk("t4.rel1A", 8'h1A, 2'b10);
        repeat (10) frame_pulse();
        chk_eq("t4.norpt", {31'd0, evt_valid}, 32'd0);

        // 18 events into a 16-entry FIFO with the consumer stalled
        for (int i = 0; i < 9; i++) begin
            keycode0_gpio = 32'h10 + i;
            cycles(40);
            keycode0_gpio = 32'h0;
            cycles(40);
        end
        chk_eq("t5.ovf.set", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            pop_chk($sformatf("t5.p%0d", i), 8'(8'h10 + i), 2'b01);
            pop_chk($sformatf("t5.r%0d", i), 8'(8'h10 + i), 2'b10);
        end
        chk_eq("t5.drained", {31'd0, evt_valid}, 32'd0);
        chk_eq("t5.ovf.sticky", {31'd0, overflow}, 32'd1);
        overflow_clr = 1'b1;
        cycles(1);
        overflow_clr = 1'b0;
        cycles(1);
        chk_eq("t5.ovf.clr", {31'd0, overflow}, 32'd0);

        // Rollover error in slot 5 blocks every commit
        keycode1_gpio = 32'h0000_0100;
        keycode0_gpio = 32'h0000_0020;
        cycles(20);
        keycode0_gpio = 32'h0000_0021;
        cycles(20);
        keycode0_gpio = 32'h0000_0022;
        cycles(30);
        chk_eq("t6.noevt", {31'd0, evt_valid}, 32'd0);
        chk_eq("t6.count", {28'd0, key_count}, 32'd0);
        keycode1_gpio = 32'h0;
        pop_chk("t6.press22", 8'h22, 2'b01);
        cycles(15);
        chk_eq("t6.count1", {28'd0, key_count}, 32'd1);
        chk_eq("t6.empty", {31'd0, evt_valid}, 32'd0);

        // Reset while a scan is in progress drops the partial diff
        keycode0_gpio = 32'h0000_0023;
        begin
            int w = 0;
            while (!evt_valid && w < 200) begin
                @(negedge clk);
                w++;
            end
            chk_eq("t7.midscan.valid", {31'd0, evt_valid}, 32'd1);
        end
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        #1;
        chk_eq("t7.rst.valid", {31'd0, evt_valid}, 32'd0);
        chk_eq("t7.rst.count", {28'd0, key_count}, 32'd0);
        @(negedge clk);
        pop_chk("t7.press23", 8'h23, 2'b01);
        cycles(15);
        chk_eq("t7.empty", {31'd0, evt_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/keycode_event_tracker.md
Name: keycode_event_tracker

Overview:
- Parametrised successor to the single-keycode path that now feeds the ball logic, which reads only keycode0_gpio[7:0].
- Tracks up to 8 concurrent USB HID keycodes from both MicroBlaze GPIO words.
- Detects press and release edges and generates frame-locked typematic repeats.
- Queues typed events in a FIFO with a valid/ready handshake, so game logic sees every key transition, not a level snapshot.
- Sits between mb_block GPIO outputs and the game/physics modules.

Parameters:
- NUM_SLOTS, 8, active keycode slots (1..8); slot k = bits [8k+7:8k] of {keycode1_gpio, keycode0_gpio].
- FIFO_DEPTH, 16, event FIFO entries; must be a power of 2 and at least 2.
- STABLE_CYCLES, 4, cycles the raw GPIO snapshot must stay unchanged before it is committed.
- REPEAT_DELAY, 30, frames a key is held before the first repeat event.
- REPEAT_RATE, 6, frames between later repeat events.

Ports:
- clk  in  1  system clock (100 MHz domain, same as mb_block).
- reset  in  1  asynchronous, active-high.
- keycode0_gpio  in  32  keycode slots 0-3.
- keycode1_gpio  in  32  keycode slots 4-7.
- frame_clk  in  1  vsync from the VGA controller; asynchronous to clk.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  consumer accepts the head event.
- evt_code  out  8  keycode of the head event.
- evt_type  out  2  01 press, 10 release, 11 repeat.
- overflow  out  1  sticky; set when an event is dropped.
- overflow_clr  in  1  clears overflow.
- key_count  out  4  number of distinct valid keys in the committed snapshot.
- any_key  out  1  key_count != 0.

Behaviour:
- Reset values:
  - FIFO empty; evt_valid=0, evt_code=0, evt_type=0.
  - overflow=0, key_count=0, any_key=0.
  - Committed snapshot all 0x00; repeat key none; FSM in IDLE; stability counter 0.
- Slot validity:
  - Code 0x00 means an empty slot.
  - If any active slot holds 0x01 (rollover error), the whole raw snapshot is treated as unstable: not committed, counter held at 0.
  - Slots at index NUM_SLOTS and above are ignored.
- Stability filter:
  - Register the raw snapshot every cycle. Any change restarts the counter at 0.
  - After STABLE_CYCLES consecutive equal cycles, the snapshot is a commit candidate.
  - If the candidate differs from the committed snapshot and FSM=IDLE, enter SCAN_REL.
  - Otherwise (FSM busy), the candidate waits; only the latest stable candidate is used.
- Diff FSM: IDLE -> SCAN_REL -> SCAN_PRESS -> IDLE. Each scan state visits one slot per cycle, NUM_SLOTS cycles per state.
  - SCAN_REL: emit a release for each valid old code that is absent from the new set.
  - SCAN_PRESS: emit a press for each valid new code that is absent from the old set.
  - Duplicate codes inside one snapshot produce a single event, from the lowest slot index.
  - In the last SCAN_PRESS cycle, the new snapshot becomes committed and key_count/any_key update on the next edge.
  - Event order: all releases in slot order, then all presses in slot order.
- Repeat engine:
  - frame_clk passes through a 2-flop synchroniser; a rising edge gives a 1-cycle frame_tick.
  - The most recent press (highest slot in the last scan) becomes the repeat key; its frame counter resets to 0.
  - On each frame_tick while the repeat key is held, the counter increments.
  - At REPEAT_DELAY, emit a repeat and reload the counter so the next repeat comes REPEAT_RATE frames later.
  - A release of the repeat key clears it (no further repeats). A new press replaces it.
- Push arbitration:
  - Scan events have priority.
  - A repeat due in the same cycle sets a pending flag, pushed on the first cycle with no scan push.
  - At most one pending repeat is held; a second one while pending is dropped and sets overflow.
- FIFO:
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - Otherwise the event is dropped and overflow=1.
  - Pop happens on evt_valid & evt_ready.
  - Outputs are registered from the head entry; a push into an empty FIFO gives evt_valid=1 on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow_clr: clears overflow. If a set and a clear occur in the same cycle, the set wins.
- Latency: a raw change stable at cycle t commits at t+STABLE_CYCLES. The first event is visible no more than 2 cycles after its scan slot is visited.
- An asynchronous reset mid-scan abandons the scan; no partial events survive.

Test Plan:
- Reset, then keycode0_gpio=0x00000004 held 10 cycles -> one event (0x04, 01); key_count=1; any_key=1.
- Raw toggles 0x04/0x00 every 2 cycles with STABLE_CYCLES=4 -> no events; key_count stays 0.
- Committed {0x04,0x07}, new {0x07,0x16} -> exactly (0x04,10) then (0x16,01); key_count=2.
- Hold 0x1A, pulse frame_clk 42 times -> repeat events after frames 30, 36 and 42 (3 total); release -> (0x1A,10), no further repeats.
- evt_ready=0, press/release 9 different keys (18 events, FIFO_DEPTH=16) -> 16 events queued, overflow=1; drain all 16 in order; pulse overflow_clr -> overflow=0.
- Slot 5 = 0x01 with others changing -> no commit and no events; clear 0x01 -> diff applied against the last committed snapshot.
